// File: rtl/set_input_delay_rx.sv
// Serial frame receiver: input ports land directly in capture flops (the input-delay targets).
// A three-process FSM then deserializes LSB-first payload bits and checks the trailing parity bit.
module set_input_delay_rx_ref_ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  // Reference flop whose clock pin is the timing reference ff_ref/clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else begin
      q <= d;
    end
  end

endmodule

module set_input_delay_rx #(
  parameter int WIDTH      = 8,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic             src_clk,
  input  logic             rst_n,
  input  logic             port1,
  input  logic             port2,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             parity_err,
  output logic             frame_abort,
  output logic             ref_q
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_PARITY = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_port1_q;
  logic             r_port2_q;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_shift;
  logic             r_acc;
  logic             w_load;
  logic             w_shift;
  logic             w_done;
  logic             w_abort;
  logic             w_ref_q;

  // Capture stage: ports go straight into flops with no logic in front
  always_ff @(posedge src_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_port1_q <= 1'b0;
      r_port2_q <= 1'b0;
    end else begin
      r_port1_q <= port1;
      r_port2_q <= port2;
    end
  end

  set_input_delay_rx_ref_ff ff_ref (
    .clk   (src_clk),
    .rst_n (rst_n),
    .d     (port1),
    .q     (w_ref_q)
  );

  assign ref_q = w_ref_q;

  // FSM state register
  always_ff @(posedge src_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a start on the last SHIFT edge aborts, a start in PARITY is back-to-back
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (r_port2_q) begin
          w_state_nxt = S_SHIFT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (r_port2_q) begin
          w_state_nxt = S_SHIFT;
        end else if (r_cnt == LAST_BIT) begin
          w_state_nxt = S_PARITY;
        end else begin
          w_state_nxt = S_SHIFT;
        end
      end
      S_PARITY: begin
        if (r_port2_q) begin
          w_state_nxt = S_SHIFT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM output decode driving the datapath
  always_comb begin
    w_load  = 1'b0;
    w_shift = 1'b0;
    w_done  = 1'b0;
    w_abort = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_load = r_port2_q;
      end
      S_SHIFT: begin
        w_load  = r_port2_q;
        w_abort = r_port2_q;
        w_shift = ~r_port2_q;
      end
      S_PARITY: begin
        w_load = r_port2_q;
        w_done = 1'b1;
      end
      default: begin
        w_load = 1'b0;
      end
    endcase
  end

  // Bit counter, shift register and parity accumulator
  always_ff @(posedge src_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_shift <= '0;
      r_acc   <= 1'b0;
    end else if (w_load) begin
      r_cnt   <= '0;
      r_shift <= '0;
      r_acc   <= PARITY_ODD;
    end else if (w_shift) begin
      r_shift[r_cnt] <= r_port1_q;
      r_acc          <= r_acc ^ r_port1_q;
      r_cnt          <= r_cnt + CW'(1);
    end else begin
      r_cnt   <= r_cnt;
      r_shift <= r_shift;
      r_acc   <= r_acc;
    end
  end

  // Registered result outputs; data_out and parity_err hold between frames
  always_ff @(posedge src_clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out    <= '0;
      data_valid  <= 1'b0;
      parity_err  <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      data_valid  <= w_done;
      frame_abort <= w_abort;
      if (w_done) begin
        data_out   <= r_shift;
        parity_err <= r_acc ^ r_port1_q;
      end else begin
        data_out   <= data_out;
        parity_err <= parity_err;
      end
    end
  end

endmodule

// File: tb/tb_set_input_delay_rx.sv
// Self-checking bench: directed frames plus random frames/restarts against a frame-level model
// that tracks start times and payload history per clock edge.
module tb_set_input_delay_rx;

  localparam int W    = 8;
  localparam bit PODD = 1'b0;

  logic         src_clk;
  logic         rst_n;
  logic         port1;
  logic         port2;
  logic [W-1:0] data_out;
  logic         data_valid;
  logic         parity_err;
  logic         frame_abort;
  logic         ref_q;

  int n_cmp;
  int n_bad;

  // model state: edge index, port1 history, active frame start edge
  int      e_idx;
  bit      hist_p1 [0:32767];
  bit      m_active;
  int      m_start;
  bit      pend_v;
  bit      pend_a;
  logic [W-1:0] exp_data;
  bit      exp_err;

  set_input_delay_rx #(.WIDTH(W), .PARITY_ODD(PODD)) dut (
    .src_clk     (src_clk),
    .rst_n       (rst_n),
    .port1       (port1),
    .port2       (port2),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .parity_err  (parity_err),
    .frame_abort (frame_abort),
    .ref_q       (ref_q)
  );

  initial src_clk = 1'b0;
  always #5 src_clk = ~src_clk;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    pend_v   = 1'b0;
    pend_a   = 1'b0;
    exp_data = '0;
    exp_err  = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk_val({tag, "_data"}, 32'(data_out), 32'd0);
    chk_val({tag, "_valid"}, 32'(data_valid), 32'd0);
    chk_val({tag, "_perr"}, 32'(parity_err), 32'd0);
    chk_val({tag, "_abort"}, 32'(frame_abort), 32'd0);
    chk_val({tag, "_refq"}, 32'(ref_q), 32'd0);
  endtask

  // One clock edge: drive ports, check outputs of this edge, then advance the model
  task automatic step(input logic p1, input logic p2);
    logic [W-1:0] d;
    bit nv;
    bit na;
    @(negedge src_clk);
    port1 = p1;
    port2 = p2;
    @(posedge src_clk);
    #1;
    e_idx++;
    hist_p1[e_idx] = p1;
    chk_val("valid", 32'(data_valid), 32'(pend_v));
    chk_val("abort", 32'(frame_abort), 32'(pend_a));
    chk_val("data", 32'(data_out), 32'(exp_data));
    chk_val("perr", 32'(parity_err), 32'(exp_err));
    chk_val("refq", 32'(ref_q), 32'(p1));
    nv = 1'b0;
    na = 1'b0;
    if (m_active && e_idx == m_start + W + 1) begin
      for (int k = 0; k < W; k++) d[k] = hist_p1[m_start + 1 + k];
      exp_data = d;
      exp_err  = (^d) ^ p1 ^ PODD;
      nv       = 1'b1;
      m_active = 1'b0;
    end
    if (p2) begin
      if (m_active) na = 1'b1;
      m_active = 1'b1;
      m_start  = e_idx;
    end
    pend_v = nv;
    pend_a = na;
  endtask

  task automatic frame_body(input logic [W-1:0] d, input bit flip, input bit start_after);
    for (int k = 0; k < W; k++) step(d[k], 1'b0);
    step((^d) ^ PODD ^ flip, start_after);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'($urandom_range(0, 1)), 1'b0);
  endtask

  initial begin
    bit          have_start;
    int          r;
    int          nb;
    logic [W-1:0] rd;
    n_cmp = 0;
    n_bad = 0;
    e_idx = 0;
    m_start = 0;
    model_reset();
    port1 = 1'b0;
    port2 = 1'b0;
    rst_n = 1'b0;

    // reset held with toggling ports
    for (int k = 0; k < 6; k++) begin
      @(negedge src_clk);
      port1 = 1'($urandom_range(0, 1));
      port2 = 1'($urandom_range(0, 1));
      @(posedge src_clk);
      #1;
      chk_all_zero("rst_hold");
    end
    port1 = 1'b0;
    port2 = 1'b0;
    rst_n = 1'b1;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    // good frame, bad parity, back-to-back, restart
    step(1'b0, 1'b1); frame_body(8'hA5, 1'b0, 1'b0); idle(3);
    step(1'b0, 1'b1); frame_body(8'h3C, 1'b1, 1'b0); idle(3);
    step(1'b0, 1'b1); frame_body(8'h01, 1'b0, 1'b1); frame_body(8'hFF, 1'b0, 1'b0); idle(3);
    step(1'b0, 1'b1);
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b1 & 1'b0); step(1'b1, 1'b0);
    step(1'b0, 1'b1); frame_body(8'h5A, 1'b0, 1'b0); idle(3);

    // async reset mid-frame, checked before the next edge
    step(1'b0, 1'b1);
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_async");
    @(negedge src_clk);
    port1 = 1'b0;
    port2 = 1'b0;
    @(posedge src_clk);
    #1;
    model_reset();
    rst_n = 1'b1;
    step(1'b0, 1'b0);
    step(1'b0, 1'b1); frame_body(8'h81, 1'b0, 1'b0); idle(3);

    // random frames, restarts, back-to-back and gaps
    have_start = 1'b0;
    for (int it = 0; it < 300; it++) begin
      if (!have_start) step(1'($urandom_range(0, 1)), 1'b1);
      have_start = 1'b0;
      r = $urandom_range(0, 9);
      if (r == 0) begin
        nb = $urandom_range(0, W - 1);
        for (int k = 0; k < nb; k++) step(1'($urandom_range(0, 1)), 1'b0);
      end else begin
        rd = W'($urandom);
        have_start = ($urandom_range(0, 3) == 0);
        frame_body(rd, ($urandom_range(0, 3) == 0), have_start);
        if (!have_start) idle($urandom_range(0, 3));
      end
    end
    if (have_start) frame_body(8'h00, 1'b0, 1'b0);
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
